data_mem_ctrl: RTL

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/dmem_pkg.sv | 39 +++
 rtl/dmem_array.sv | 27 ++
 rtl/data_mem_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data memory controller: access size encoding, FSM states,
// and the byte-lane helpers used by both the controller and its storage.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } dmem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Low address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] align_mask(input dmem_size_e size);
    case (size)
      SZ_BYTE: return 3'b000;
      SZ_HALF: return 3'b001;
      SZ_WORD: return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [7:0] lane_mask(input dmem_size_e size, input logic [2:0] lane);
    logic [7:0] base;
    case (size)
      SZ_BYTE: base = 8'h01;
      SZ_HALF: base = 8'h03;
      SZ_WORD: base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lane;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64 storage with one synchronous read/write port and per-byte write enables.
// Read data is the word content before any write on the same edge.
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [7:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 8; b++) begin
        if (we && be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Fixed-latency data memory controller: IDLE -> WAIT -> RESP, byte/half/word/dword
// loads and stores. Define DMEM_MISALIGN_CHECK_EN to fault misaligned accesses.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err
);

  localparam int             IW       = ADDR_W - 3;
  localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW:0]    DEPTH_L  = (IW + 1)'(DEPTH);
  localparam logic [3:0]     CNT_INIT = 4'(WAIT_CYCLES - 1);

  // Handshake: a request is taken on a rising edge with req_valid && req_ready;
  // req_ready is high only in IDLE and the response cannot be stalled.
  dmem_state_e state, state_nxt;
  logic [3:0]    cnt;
  logic          wr_q, sgn_q, err_q;
  dmem_size_e    size_q;
  logic [2:0]    lane_q;
  logic [AW-1:0] idx_q;
  logic [63:0]   wdata_q;

  dmem_size_e  req_sz;
  logic [2:0]  req_lane;
  logic        req_err;
  logic        accept, commit;
  logic [63:0] arr_rdata, shifted, load_val;

  assign req_sz = dmem_size_e'(req_size);
  assign accept = req_valid && (state == ST_IDLE);
  assign commit = (state == ST_WAIT) && (cnt == 4'd0);

  always_comb begin
    req_err  = ({1'b0, req_addr[ADDR_W-1:3]} >= DEPTH_L);
`ifdef DMEM_MISALIGN_CHECK_EN
    req_lane = req_addr[2:0];
    if (|(req_addr[2:0] & align_mask(req_sz))) req_err = 1'b1;
`else
    req_lane = req_addr[2:0] & ~align_mask(req_sz);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_WAIT;
      ST_WAIT: if (cnt == 4'd0) state_nxt = ST_RESP;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      lane_q  <= 3'd0;
      idx_q   <= '0;
      wdata_q <= 64'd0;
    end else if (accept) begin
      cnt     <= CNT_INIT;
      wr_q    <= req_write;
      sgn_q   <= req_signed;
      err_q   <= req_err;
      size_q  <= req_sz;
      lane_q  <= req_lane;
      idx_q   <= req_addr[AW+2:3];
      wdata_q <= req_wdata;
    end else if (state == ST_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Faulted accesses never touch the array, so an out-of-range index cannot alias.
  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .en    (commit && !err_q),
    .we    (wr_q),
    .be    (lane_mask(size_q, lane_q)),
    .idx   (idx_q),
    .wdata (wdata_q << {lane_q, 3'b000}),
    .rdata (arr_rdata)
  );

  always_comb begin
    shifted = arr_rdata >> {lane_q, 3'b000};
    case (size_q)
      SZ_BYTE: load_val = {{56{sgn_q & shifted[7]}},  shifted[7:0]};
      SZ_HALF: load_val = {{48{sgn_q & shifted[15]}}, shifted[15:0]};
      SZ_WORD: load_val = {{32{sgn_q & shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    req_ready  = (state == ST_IDLE);
    resp_valid = (state == ST_RESP);
    resp_err   = (state == ST_RESP) && err_q;
    resp_rdata = (state == ST_RESP && !err_q && !wr_q) ? load_val : 64'd0;
  end

endmodule
